regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x64 LEGv8 register file between NUM_REQ writeback sources (e.g. ALU writeback, load writeback).
- Round-robin arbitration, valid/ready handshake per requester, and one registered output stage driving the regfile write port.
- Drops writes to X31 (XZR) and reports a pending-write hazard for one query address, for forwarding/stall logic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 64, register data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester destination register.
- req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_ready  output  NUM_REQ  one-hot-or-zero grant; request accepted when valid and ready are both high at posedge.
- wr_stall  input  1  regfile side cannot accept a write this cycle.
- wr_en  output  1  regfile write enable (registered).
- wr_addr  output  ADDR_WIDTH  regfile write address (registered).
- wr_data  output  DATA_WIDTH  regfile write data (registered).
- query_addr  input  ADDR_WIDTH  register being read by the consumer.
- query_pending  output  1  output stage holds an unretired write to query_addr.

Behaviour:
- Reset (synchronous, active-high): wr_en=0, wr_addr=0, wr_data=0, rr pointer=0. req_ready=0 and query_pending=0 while reset is high, regardless of other inputs.
- Output stage is "free" when wr_en=0, or when wr_en=1 and wr_stall=0 (the write retires this cycle).
- Arbitration is combinational:
  - Only if the stage is free and reset=0, search req_valid from index ptr upward, modulo NUM_REQ.
  - The first valid index wins; req_ready is asserted for the winner only.
  - If no requester is valid, or the stage is not free, req_ready is all zeros.
- Accept at posedge N:
  - ptr <= (winner+1) mod NUM_REQ.
  - Output stage loads the winner's addr and data.
  - wr_en <= 1 unless req_addr == 31 (XZR). An XZR write is acknowledged but issues no write: wr_en <= 0, wr_addr and wr_data are loaded anyway.
  - Latency: the write appears on the port in cycle N+1.
- No accept, stage free: wr_en <= 0; wr_addr and wr_data hold their previous values.
- Stall (wr_en=1 and wr_stall=1):
  - wr_en, wr_addr and wr_data hold.
  - No grants; ptr unchanged.
  - The write retires in the first cycle in which wr_stall=0.
- wr_stall while wr_en=0 has no effect; the stage is free.
- Back-to-back operation: a retire and a new accept occur in the same cycle, so with wr_stall=0 one write per cycle is sustained.
- Fairness: with all requesters continuously valid and no stall, grants rotate strictly 0,1,...,NUM_REQ-1,0,...
- ptr advances only on an accept. An idle cycle leaves ptr unchanged.
- Requesters may drop req_valid without a grant; the arbiter holds no state per requester.
- query_pending = wr_en & (wr_addr == query_addr) & (query_addr != 31). It is combinational from the registered stage. The consumer must read the regfile only after pending clears, or forward wr_data.
- Reset asserted mid-stall: the pending write is discarded and wr_en=0 on the next cycle.
- Reset has priority over all other events.
- NUM_REQ is not a power of two (e.g. 3): the modulo wrap must go from NUM_REQ-1 to 0, never to an unused index.

Test Plan:
- Reset then idle: assert reset 2 cycles with req_valid=2'b11. Required: req_ready=0 throughout, wr_en=0, wr_addr=0, wr_data=0. After release, req_ready=2'b01 (ptr=0).
- Single write latency: req0 writes X5=64'hDEADBEEF_00000001 at cycle N. Required: cycle N+1 wr_en=1, wr_addr=5, wr_data=64'hDEADBEEF_00000001, query_pending=1 for query_addr=5. Cycle N+2: wr_en=0.
- Round-robin: both valid for 4 cycles (req0 addr 1, req1 addr 2), no stall. Required: grants 0,1,0,1; wr_addr sequence 1,2,1,2 on consecutive cycles.
- Stall hold: stage holds X7 and wr_stall=1 for 3 cycles with req1 valid. Required: wr_en/wr_addr=7 held for 3 cycles, req_ready=0 during the stall. When wr_stall drops, req1 is granted the same cycle and its write appears the next cycle.
- XZR drop: req1 writes addr 31 data 64'h1. Required: req_ready[1]=1, next cycle wr_en=0, query_pending=0 for query_addr=31, ptr advances to 0.
- Reset mid-stall with NUM_REQ=3: set ptr=2 and hold a stalled write, then assert reset. Required: wr_en=0 next cycle. After release with all three valid, grant order is 0,1,2,0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the LEGv8 register file write port between NUM_REQ
// writeback sources, with one registered output stage, XZR drop and a pending-write query.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 wr_stall,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [ADDR_WIDTH-1:0]                query_addr,
  output logic                                 query_pending
);

  localparam int                    PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] XZR   = ADDR_WIDTH'(31);
  localparam logic [PTR_W-1:0]      LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  logic             stage_free;

  // The stage can take a new write when empty or when its current write retires now.
  assign stage_free = !wr_en || !wr_stall;

  always_comb begin
    req_ready = '0;
    winner    = '0;
    found     = 1'b0;
    cand      = ptr;
    if (!reset && stage_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
        cand = (cand == LAST) ? '0 : cand + 1'b1;
      end
    end
    if (found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Wrap explicitly so a non-power-of-two NUM_REQ never lands on an unused index.
  assign next_ptr = (winner == LAST) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (stage_free) begin
      if (found) begin
        ptr     <= next_ptr;
        wr_addr <= req_addr[winner];
        wr_data <= req_data[winner];
        wr_en   <= (req_addr[winner] != XZR);
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

  assign query_pending = !reset && wr_en && (wr_addr == query_addr) && (query_addr != XZR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table on a 2-requester instance,
// a 3-requester reset-mid-stall sequence, and randomized runs against a reference model.
module tb_regfile_write_arbiter;

  localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
  localparam logic [63:0] DA = 64'hA0, DB = 64'hB0, DC = 64'hC0, DE = 64'hE0;
  localparam logic [63:0] DF = 64'hF0, DG = 64'h60, DH = 64'h70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst2, st2, en2, qp2;
  logic [1:0]       v2, rdy2;
  logic [1:0][4:0]  a2;
  logic [1:0][63:0] d2;
  logic [4:0]       q2, wa2;
  logic [63:0]      wd2;

  logic             rst3, st3, en3, qp3;
  logic [2:0]       v3, rdy3;
  logic [2:0][4:0]  a3;
  logic [2:0][63:0] d3;
  logic [4:0]       q3, wa3;
  logic [63:0]      wd3;

  regfile_write_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(64)) dut2 (
    .clk(clk), .reset(rst2), .req_valid(v2), .req_addr(a2), .req_data(d2),
    .req_ready(rdy2), .wr_stall(st2), .wr_en(en2), .wr_addr(wa2), .wr_data(wd2),
    .query_addr(q2), .query_pending(qp2));

  regfile_write_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(64)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_addr(a3), .req_data(d3),
    .req_ready(rdy3), .wr_stall(st3), .wr_en(en3), .wr_addr(wa3), .wr_data(wd3),
    .query_addr(q3), .query_pending(qp3));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          ptr;
    bit          en;
    logic [4:0]  addr;
    logic [63:0] data;
  } model_t;

  model_t m2, m3;

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic        st;
    logic [4:0]  q;
    logic [1:0]  ready;
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        qp;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan requesters from ptr modulo n, first valid wins; stage modelled as a record.
  task automatic model_step(inout model_t m, input int n, input string tag,
                            input bit rst, input logic [7:0] v, input logic [7:0][4:0] a,
                            input logic [7:0][63:0] d, input bit st, input logic [4:0] q,
                            input logic [7:0] act_ready, input logic act_en,
                            input logic [4:0] act_addr, input logic [63:0] act_data,
                            input logic act_qp);
    int         win = -1;
    bit         free = !m.en || !st;
    logic [7:0] exp_ready = '0;
    logic [2:0] idx;
    bit         exp_qp;
    if (!rst && free) begin
      for (int k = 0; k < n; k++) begin
        idx = 3'((m.ptr + k) % n);
        if (win < 0 && v[idx]) win = int'(idx);
      end
    end
    if (win >= 0) exp_ready[3'(win)] = 1'b1;
    exp_qp = !rst && m.en && (m.addr == q) && (q != 5'd31);
    check($sformatf("%s ready", tag), 64'(act_ready), 64'(exp_ready));
    check($sformatf("%s wr_en", tag), 64'(act_en), 64'(m.en));
    check($sformatf("%s wr_addr", tag), 64'(act_addr), 64'(m.addr));
    check($sformatf("%s wr_data", tag), act_data, m.data);
    check($sformatf("%s pending", tag), 64'(act_qp), 64'(exp_qp));
    if (rst) begin
      m = '{0, 1'b0, 5'd0, 64'd0};
    end else if (free) begin
      if (win >= 0) begin
        m.ptr  = (win + 1) % n;
        m.addr = a[3'(win)];
        m.data = d[3'(win)];
        m.en   = (a[3'(win)] != 5'd31);
      end else begin
        m.en = 1'b0;
      end
    end
  endtask

  task automatic step2_model(input string tag);
    model_step(m2, 2, tag, rst2, {6'b0, v2}, {30'b0, a2}, {384'b0, d2}, st2, q2,
               {6'b0, rdy2}, en2, wa2, wd2, qp2);
  endtask

  task automatic step3(input logic rst, input logic [2:0] v, input logic st,
                       input logic [4:0] q, input string tag);
    @(negedge clk);
    rst3 = rst; v3 = v; st3 = st; q3 = q;
    #1;
    model_step(m3, 3, tag, rst3, {5'b0, v3}, {25'b0, a3}, {320'b0, d3}, st3, q3,
               {5'b0, rdy3}, en3, wa3, wd3, qp3);
  endtask

  initial begin
    // Fields: rst, valid, a0, a1, d0, d1, stall, query | ready, wr_en, wr_addr, wr_data, pending
    tbl[0]  = '{1'b1, 2'b11, 5'd0, 5'd0,  64'd0, 64'd0, 1'b0, 5'd0,  2'b00, 1'b0, 5'd0,  64'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 5'd0, 5'd0,  64'd0, 64'd0, 1'b0, 5'd0,  2'b00, 1'b0, 5'd0,  64'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 5'd5, 5'd0,  D1,    64'd0, 1'b0, 5'd5,  2'b01, 1'b0, 5'd0,  64'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 5'd5, 5'd0,  D1,    64'd0, 1'b0, 5'd5,  2'b00, 1'b1, 5'd5,  D1,    1'b1};
    tbl[4]  = '{1'b0, 2'b00, 5'd5, 5'd0,  D1,    64'd0, 1'b0, 5'd5,  2'b00, 1'b0, 5'd5,  D1,    1'b0};
    tbl[5]  = '{1'b0, 2'b10, 5'd0, 5'd9,  64'd0, DC,    1'b0, 5'd0,  2'b10, 1'b0, 5'd5,  D1,    1'b0};
    tbl[6]  = '{1'b0, 2'b11, 5'd1, 5'd2,  DA,    DB,    1'b0, 5'd1,  2'b01, 1'b1, 5'd9,  DC,    1'b0};
    tbl[7]  = '{1'b0, 2'b11, 5'd1, 5'd2,  DA,    DB,    1'b0, 5'd1,  2'b10, 1'b1, 5'd1,  DA,    1'b1};
    tbl[8]  = '{1'b0, 2'b11, 5'd1, 5'd2,  DA,    DB,    1'b0, 5'd1,  2'b01, 1'b1, 5'd2,  DB,    1'b0};
    tbl[9]  = '{1'b0, 2'b11, 5'd1, 5'd2,  DA,    DB,    1'b0, 5'd1,  2'b10, 1'b1, 5'd1,  DA,    1'b1};
    tbl[10] = '{1'b0, 2'b00, 5'd1, 5'd2,  DA,    DB,    1'b0, 5'd2,  2'b00, 1'b1, 5'd2,  DB,    1'b1};
    tbl[11] = '{1'b0, 2'b01, 5'd7, 5'd0,  DE,    64'd0, 1'b0, 5'd7,  2'b01, 1'b0, 5'd2,  DB,    1'b0};
    tbl[12] = '{1'b0, 2'b10, 5'd7, 5'd3,  DE,    DF,    1'b1, 5'd7,  2'b00, 1'b1, 5'd7,  DE,    1'b1};
    tbl[13] = '{1'b0, 2'b10, 5'd7, 5'd3,  DE,    DF,    1'b1, 5'd7,  2'b00, 1'b1, 5'd7,  DE,    1'b1};
    tbl[14] = '{1'b0, 2'b10, 5'd7, 5'd3,  DE,    DF,    1'b1, 5'd7,  2'b00, 1'b1, 5'd7,  DE,    1'b1};
    tbl[15] = '{1'b0, 2'b10, 5'd7, 5'd3,  DE,    DF,    1'b0, 5'd7,  2'b10, 1'b1, 5'd7,  DE,    1'b1};
    tbl[16] = '{1'b0, 2'b00, 5'd7, 5'd3,  DE,    DF,    1'b0, 5'd3,  2'b00, 1'b1, 5'd3,  DF,    1'b1};
    tbl[17] = '{1'b0, 2'b01, 5'd4, 5'd3,  DG,    DF,    1'b1, 5'd3,  2'b01, 1'b0, 5'd3,  DF,    1'b0};
    tbl[18] = '{1'b0, 2'b10, 5'd4, 5'd31, DG,    64'd1, 1'b0, 5'd31, 2'b10, 1'b1, 5'd4,  DG,    1'b0};
    tbl[19] = '{1'b0, 2'b11, 5'd6, 5'd8,  DH,    64'd1, 1'b0, 5'd31, 2'b01, 1'b0, 5'd31, 64'd1, 1'b0};
    tbl[20] = '{1'b0, 2'b00, 5'd6, 5'd8,  DH,    64'd1, 1'b1, 5'd6,  2'b00, 1'b1, 5'd6,  DH,    1'b1};
    tbl[21] = '{1'b1, 2'b11, 5'd6, 5'd8,  DH,    64'd1, 1'b1, 5'd6,  2'b00, 1'b1, 5'd6,  DH,    1'b0};
    tbl[22] = '{1'b0, 2'b11, 5'd6, 5'd8,  DH,    64'd1, 1'b0, 5'd6,  2'b01, 1'b0, 5'd0,  64'd0, 1'b0};

    rst2 = 1'b1; v2 = '0; a2 = '0; d2 = '0; st2 = 1'b0; q2 = '0;
    rst3 = 1'b1; v3 = '0; st3 = 1'b0; q3 = '0;
    a3 = {5'd12, 5'd11, 5'd10};
    d3 = {64'h3333, 64'h2222, 64'h1111};
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst2 = tbl[i].rst; v2 = tbl[i].v; a2[0] = tbl[i].a0; a2[1] = tbl[i].a1;
      d2[0] = tbl[i].d0; d2[1] = tbl[i].d1; st2 = tbl[i].st; q2 = tbl[i].q;
      #1;
      check($sformatf("row%0d ready", i), 64'(rdy2), 64'(tbl[i].ready));
      check($sformatf("row%0d wr_en", i), 64'(en2), 64'(tbl[i].en));
      check($sformatf("row%0d wr_addr", i), 64'(wa2), 64'(tbl[i].addr));
      check($sformatf("row%0d wr_data", i), wd2, tbl[i].data);
      check($sformatf("row%0d pending", i), 64'(qp2), 64'(tbl[i].qp));
    end

    @(negedge clk);
    rst2 = 1'b1; v2 = '0; st2 = 1'b0;
    @(negedge clk);
    m2 = '{0, 1'b0, 5'd0, 64'd0};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst2 = ($urandom_range(0, 49) == 0);
      v2   = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        a2[r] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d2[r] = {$urandom, $urandom};
      end
      st2 = ($urandom_range(0, 2) == 0);
      q2  = ($urandom_range(0, 1) == 1) ? m2.addr : 5'($urandom_range(0, 31));
      #1;
      step2_model($sformatf("rand2 #%0d", i));
    end

    // Three requesters: park ptr at 2 with a stalled write, reset, then check 0,1,2,0 rotation.
    m3 = '{0, 1'b0, 5'd0, 64'd0};
    step3(1'b0, 3'b111, 1'b0, 5'd0, "n3 g0");
    check("n3 first grant", 64'(rdy3), 64'(3'b001));
    step3(1'b0, 3'b111, 1'b0, 5'd11, "n3 g1");
    check("n3 second grant", 64'(rdy3), 64'(3'b010));
    step3(1'b0, 3'b000, 1'b1, 5'd11, "n3 stall");
    check("n3 stalled wr_en", 64'(en3), 64'(1'b1));
    step3(1'b1, 3'b111, 1'b1, 5'd11, "n3 reset");
    check("n3 ready in reset", 64'(rdy3), 64'(3'b000));
    step3(1'b0, 3'b111, 1'b0, 5'd11, "n3 post0");
    check("n3 wr_en after reset", 64'(en3), 64'(1'b0));
    check("n3 post grant 0", 64'(rdy3), 64'(3'b001));
    step3(1'b0, 3'b111, 1'b0, 5'd10, "n3 post1");
    check("n3 post grant 1", 64'(rdy3), 64'(3'b010));
    step3(1'b0, 3'b111, 1'b0, 5'd11, "n3 post2");
    check("n3 post grant 2", 64'(rdy3), 64'(3'b100));
    step3(1'b0, 3'b111, 1'b0, 5'd12, "n3 post3");
    check("n3 wrap grant 0", 64'(rdy3), 64'(3'b001));

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst3 = ($urandom_range(0, 49) == 0);
      v3   = 3'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++) begin
        a3[r] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d3[r] = {$urandom, $urandom};
      end
      st3 = ($urandom_range(0, 2) == 0);
      q3  = ($urandom_range(0, 1) == 1) ? m3.addr : 5'($urandom_range(0, 31));
      #1;
      model_step(m3, 3, $sformatf("rand3 #%0d", i), rst3, {5'b0, v3}, {25'b0, a3},
                 {320'b0, d3}, st3, q3, {5'b0, rdy3}, en3, wa3, wd3, qp3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
